// File: rtl/key_capture_pkg.sv
// Shared definitions for the decimal key capture stage and the encoder bench.
// Holds the capture FSM state encoding, the key line count and the one-hot
// and multi-key helper functions.
package key_capture_pkg;

   localparam int N_KEYS = 10;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   // True when exactly one key line is active.
   function automatic logic is_onehot(input logic [N_KEYS-1:0] v);
      return ($countones(v) == 1);
   endfunction

   // True when two or more key lines are active at once.
   function automatic logic is_multi(input logic [N_KEYS-1:0] v);
      return ($countones(v) > 1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a bus of asynchronous level signals.
// Each bit is synchronised independently. Bits may resolve on different
// cycles during a transition, which the debounce logic downstream absorbs.
// Ports:
//   clk   - sampling clock, rising edge
//   rst_n - asynchronous active-low reset, clears both stages
//   d     - asynchronous input bus
//   q     - synchronised output bus
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/decimal_key_capture_10.sv
// Decimal key capture: synchronises and debounces ten raw key lines, rejects
// multi-key presses and presents a held one-hot code with a one-cycle strobe
// per accepted press, ready for the one-hot-to-excess-3 encoder.
// Optional feature macro: KEY_CAPTURE_REPEAT_EN
//   When defined, a held key re-issues key_valid every REPEAT_CYCLES cycles.
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   keys_raw   - raw key lines, bit i = digit i pressed (asynchronous)
//   key_onehot - last accepted key, one-hot; zero until the first accept
//   key_valid  - one-cycle strobe when key_onehot is (re)issued
//   key_held   - high while the accepted key stays stably pressed
//   err_multi  - one-cycle strobe when several keys are seen while idle
module decimal_key_capture_10
   import key_capture_pkg::*;
#(
   parameter int N          = N_KEYS,
   parameter int DEB_CYCLES = 8,
   parameter int CNT_W      = 4
`ifdef KEY_CAPTURE_REPEAT_EN
   ,
   parameter int REPEAT_CYCLES = 16,
   parameter int RPT_W         = 5
`endif
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] keys_raw,
   output logic [N-1:0] key_onehot,
   output logic         key_valid,
   output logic         key_held,
   output logic         err_multi
);

   logic [N-1:0] keys_s;
   logic         single;
   logic         multi;

   state_t       state_q, state_d;
   logic [N-1:0] cand_q, cand_d;
   logic [N-1:0] key_onehot_q, key_onehot_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic         key_valid_q, key_valid_d;
   logic         key_held_q, key_held_d;
   logic         err_multi_q, err_multi_d;
   logic         multi_seen_q, multi_seen_d;
`ifdef KEY_CAPTURE_REPEAT_EN
   logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

   sync_2ff #(.WIDTH(N)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (keys_raw),
      .q     (keys_s)
   );

   assign single = ($countones(keys_s) == 1);
   assign multi  = ($countones(keys_s) > 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cand_q       <= '0;
         key_onehot_q <= '0;
         cnt_q        <= '0;
         key_valid_q  <= 1'b0;
         key_held_q   <= 1'b0;
         err_multi_q  <= 1'b0;
         multi_seen_q <= 1'b0;
`ifdef KEY_CAPTURE_REPEAT_EN
         rpt_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         cand_q       <= cand_d;
         key_onehot_q <= key_onehot_d;
         cnt_q        <= cnt_d;
         key_valid_q  <= key_valid_d;
         key_held_q   <= key_held_d;
         err_multi_q  <= err_multi_d;
         multi_seen_q <= multi_seen_d;
`ifdef KEY_CAPTURE_REPEAT_EN
         rpt_q        <= rpt_d;
`endif
      end
   end

   // A multi-key chord held in IDLE raises err_multi only on the first
   // cycle it is seen; multi_seen remembers that it was already reported.
   always_comb begin
      state_d      = state_q;
      cand_d       = cand_q;
      key_onehot_d = key_onehot_q;
      cnt_d        = cnt_q;
      key_valid_d  = 1'b0;
      err_multi_d  = 1'b0;
      multi_seen_d = (state_q == IDLE) && multi;

      case (state_q)
         IDLE: begin
            if (single) begin
               cand_d  = keys_s;
               cnt_d   = '0;
               state_d = DEBOUNCE;
            end else if (multi && !multi_seen_q) begin
               err_multi_d = 1'b1;
            end
         end
         DEBOUNCE: begin
            if (keys_s == cand_q) begin
               if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                  key_onehot_d = cand_q;
                  key_valid_d  = 1'b1;
                  cnt_d        = '0;
                  state_d      = PRESSED;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         PRESSED: begin
            if (keys_s != cand_q) begin
               cnt_d   = '0;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            // Release needs an unbroken run of all-zero samples.
            if (keys_s != '0) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

`ifdef KEY_CAPTURE_REPEAT_EN
      // Repeat counter runs only while the key stays in PRESSED and is
      // zero on entry, so the first repeat lands REPEAT_CYCLES after accept.
      rpt_d = '0;
      if ((state_q == PRESSED) && (keys_s == cand_q)) begin
         if (rpt_q == RPT_W'(REPEAT_CYCLES - 1)) begin
            key_valid_d = 1'b1;
         end else begin
            rpt_d = rpt_q + 1'b1;
         end
      end
`endif

      key_held_d = (state_d == PRESSED);
   end

   assign key_onehot = key_onehot_q;
   assign key_valid  = key_valid_q;
   assign key_held   = key_held_q;
   assign err_multi  = err_multi_q;

endmodule

// File: tb/tb_decimal_key_capture_10.sv
// Self-checking bench for decimal_key_capture_10: directed scenarios followed
// by randomized key activity, all compared cycle by cycle with a behavioural
// model of the capture rules kept in this file.
module tb_decimal_key_capture_10;
   import key_capture_pkg::*;

   localparam int DEB = 8;
`ifdef KEY_CAPTURE_REPEAT_EN
   localparam int RPT = 16;
`endif

   logic       clk;
   logic       rst_n;
   logic [9:0] keys_raw;
   logic [9:0] key_onehot;
   logic       key_valid;
   logic       key_held;
   logic       err_multi;

   int compared;
   int mismatched;

   int edgeIdx;
   int firstValidEdge;
   int validCount;
   int errCount;

   // Behavioural model: a list of raw samples still in flight through the
   // synchroniser, plus the capture rules expressed as named phases.
   logic [9:0] inFlight[$];
   string      phase;
   logic [9:0] cand;
   int         stableRun;
   int         heldRun;
   logic       chordReported;
   logic [9:0] expOnehot;
   logic       expValid;
   logic       expHeld;
   logic       expErr;

   decimal_key_capture_10 dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .keys_raw   (keys_raw),
      .key_onehot (key_onehot),
      .key_valid  (key_valid),
      .key_held   (key_held),
      .err_multi  (err_multi)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t",
                  tag, observed, expected, $time);
      end
   endtask

   function automatic logic [3:0] excess3(input logic [9:0] onehot);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (onehot[i]) r = 4'(i + 3);
      end
      return r;
   endfunction

   task automatic modelReset();
      inFlight      = {10'd0, 10'd0};
      phase         = "idle";
      cand          = '0;
      stableRun     = 0;
      heldRun       = 0;
      chordReported = 1'b0;
      expOnehot     = '0;
      expValid      = 1'b0;
      expHeld       = 1'b0;
      expErr        = 1'b0;
   endtask

   // One clock edge of the model; k is the raw value sampled at this edge.
   task automatic modelStep(input logic [9:0] k);
      logic [9:0] seen;
      int         ones;
      logic       wasChord;
      seen     = inFlight.pop_front();
      inFlight.push_back(k);
      ones     = $countones(seen);
      expValid = 1'b0;
      expErr   = 1'b0;
      wasChord = (phase == "idle") && (ones > 1);

      if (phase == "idle") begin
         if (ones == 1) begin
            cand      = seen;
            stableRun = 1;
            phase     = "debounce";
         end else if (ones > 1 && !chordReported) begin
            expErr = 1'b1;
         end
      end else if (phase == "debounce") begin
         if (seen != cand) begin
            phase = "idle";
         end else if (stableRun == DEB) begin
            expOnehot = cand;
            expValid  = 1'b1;
            heldRun   = 0;
            phase     = "pressed";
         end else begin
            stableRun++;
         end
      end else if (phase == "pressed") begin
         if (seen != cand) begin
            stableRun = 0;
            phase     = "release";
         end else begin
            heldRun++;
`ifdef KEY_CAPTURE_REPEAT_EN
            if (heldRun % RPT == 0) expValid = 1'b1;
`endif
         end
      end else begin
         if (seen != 0) stableRun = 0;
         else stableRun++;
         if (stableRun == DEB) phase = "idle";
      end
      chordReported = wasChord;
      expHeld       = (phase == "pressed");
   endtask

   task automatic compareAll();
      checkOutput("key_onehot", 32'(key_onehot), 32'(expOnehot));
      checkOutput("key_valid", 32'(key_valid), 32'(expValid));
      checkOutput("key_held", 32'(key_held), 32'(expHeld));
      checkOutput("err_multi", 32'(err_multi), 32'(expErr));
      checkOutput("onehot_shape", 32'(is_onehot(key_onehot) || key_onehot == 0), 32'd1);
   endtask

   // Drives k for the given number of cycles; entered and left at a negedge.
   task automatic applyStimulus(input logic [9:0] k, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         keys_raw = k;
         @(posedge clk);
         modelStep(k);
         @(negedge clk);
         if (key_valid) begin
            validCount++;
            if (firstValidEdge < 0) firstValidEdge = edgeIdx;
         end
         if (err_multi) errCount++;
         edgeIdx++;
         compareAll();
      end
   endtask

   task automatic clearTally();
      edgeIdx        = 0;
      firstValidEdge = -1;
      validCount     = 0;
      errCount       = 0;
   endtask

   initial begin
      logic [9:0] v;
      compared   = 0;
      mismatched = 0;
      keys_raw   = '0;
      rst_n      = 1'b0;
      modelReset();
      clearTally();
      #1;
      compareAll();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Press and hold digit 2.
      clearTally();
      applyStimulus(10'b0000000100, 20);
      checkOutput("press_latency", 32'(firstValidEdge), 32'(DEB + 2));
`ifndef KEY_CAPTURE_REPEAT_EN
      checkOutput("press_count", 32'(validCount), 32'd1);
`endif
      checkOutput("press_enc", 32'(excess3(key_onehot)), 32'b0101);
      checkOutput("press_held", 32'(key_held), 32'd1);
      applyStimulus(10'b0, 14);

      // Bounce on digit 0 never settles long enough.
      clearTally();
      for (int i = 0; i < 5; i++) begin
         applyStimulus((i % 2 == 0) ? 10'b0000000001 : 10'b0, 3);
      end
      applyStimulus(10'b0, 4);
      checkOutput("bounce_count", 32'(validCount), 32'd0);
      checkOutput("bounce_onehot", 32'(key_onehot), 32'b0000000100);

      // Two keys together while idle.
      clearTally();
      applyStimulus(10'b0000100001, 12);
      checkOutput("multi_err", 32'(errCount), 32'd1);
      checkOutput("multi_valid", 32'(validCount), 32'd0);
      applyStimulus(10'b0, 4);

      // Accept digit 9, bounce on release, then accept digit 0.
      clearTally();
      applyStimulus(10'b1000000000, 14);
      for (int i = 0; i < 5; i++) begin
         applyStimulus((i % 2 == 0) ? 10'b0 : 10'b1000000000, 1);
      end
      applyStimulus(10'b0, 12);
      checkOutput("release_count", 32'(validCount), 32'd1);
      applyStimulus(10'b0000000001, 14);
      checkOutput("release_next", 32'(key_onehot), 32'b0000000001);
      checkOutput("release_enc", 32'(excess3(key_onehot)), 32'b0011);
      applyStimulus(10'b0, 12);

      // Reset in the middle of debouncing digit 3.
      clearTally();
      applyStimulus(10'b0000001000, 7);
      #2;
      rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput("async_rst_onehot", 32'(key_onehot), 32'd0);
      compareAll();
      @(negedge clk);
      keys_raw = '0;
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(10'b0, 15);
      checkOutput("async_rst_valid", 32'(validCount), 32'd0);

      // Randomized key activity.
      for (int s = 0; s < 300; s++) begin
         case ($urandom_range(0, 4))
            0: applyStimulus(10'b0, $urandom_range(1, 12));
            1: begin
               v = 10'(1 << $urandom_range(0, 9));
               applyStimulus(v, $urandom_range(1, 25));
            end
            2: begin
               v = 10'(1 << $urandom_range(0, 9));
               for (int b = 0; b < int'($urandom_range(2, 6)); b++) begin
                  applyStimulus((b % 2 == 0) ? v : 10'b0, $urandom_range(1, 4));
               end
            end
            3: begin
               v = 10'(1 << $urandom_range(0, 4)) | 10'(1 << $urandom_range(5, 9));
               v = v | 10'($urandom_range(0, 1023) & $urandom_range(0, 1023));
               applyStimulus(v, $urandom_range(1, 6));
            end
            default: applyStimulus(10'($urandom_range(0, 1023)), $urandom_range(1, 5));
         endcase
      end
      applyStimulus(10'b0, 12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
